intra_pred_engine: RTL and testbench

INTRA_PRED_ENGINE -- requirements
Module: intra_pred_engine

---
 rtl/intra_pred_engine.sv | 214 +++++++++++++++++++++
 tb/tb_intra_pred_engine.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/intra_pred_engine.sv
// Intra prediction engine: latches one block request (mode, edge samples,
// availability flags), computes the DC value in a single cycle, then emits
// the predicted block one row per accepted handshake.
module intra_pred_engine #(
    parameter int BIT_WIDTH  = 8,
    parameter int BLOCK_SIZE = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [1:0]                       mode,
    input  logic                             top_avail,
    input  logic                             left_avail,
    input  logic [BIT_WIDTH-1:0]             top_left,
    input  logic [BIT_WIDTH*BLOCK_SIZE-1:0]  top,
    input  logic [BIT_WIDTH*BLOCK_SIZE-1:0]  left,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [BIT_WIDTH*BLOCK_SIZE-1:0]  out_row,
    output logic [$clog2(BLOCK_SIZE)-1:0]    out_row_idx,
    output logic                             out_last
);

    localparam int IDX_W = $clog2(BLOCK_SIZE);
    localparam int ACC_W = BIT_WIDTH + IDX_W + 1;
    localparam int ROW_W = BIT_WIDTH * BLOCK_SIZE;

    localparam logic [BIT_WIDTH-1:0] ONE_PIX  = {{(BIT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [BIT_WIDTH-1:0] MID_PIX  = {1'b1, {(BIT_WIDTH-1){1'b0}}};
    localparam logic [BIT_WIDTH-1:0] MID_P1   = MID_PIX + ONE_PIX;
    localparam logic [BIT_WIDTH-1:0] MID_M1   = MID_PIX - ONE_PIX;
    localparam logic [IDX_W-1:0]     ONE_IDX  = {{(IDX_W-1){1'b0}}, 1'b1};
    localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(BLOCK_SIZE - 1);

    localparam logic [1:0] MODE_DC = 2'd0;
    localparam logic [1:0] MODE_TM = 2'd1;
    localparam logic [1:0] MODE_V  = 2'd2;
    localparam logic [1:0] MODE_H  = 2'd3;

    // Only the power-of-two sizes the rounding shifts are built for
    if ((BLOCK_SIZE != 4) && (BLOCK_SIZE != 8) && (BLOCK_SIZE != 16)) begin : g_bad_block_size
        $error("intra_pred_engine: BLOCK_SIZE must be 4, 8 or 16");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_EMIT = 2'd2
    } state_t;

    state_t                 state_r;
    logic [1:0]             mode_r;
    logic                   top_avail_r;
    logic                   left_avail_r;
    logic [BIT_WIDTH-1:0]   top_left_r;
    logic [ROW_W-1:0]       top_r;
    logic [ROW_W-1:0]       left_r;
    logic [BIT_WIDTH-1:0]   dc_r;
    logic [IDX_W-1:0]       row_cnt_r;

    logic [ACC_W-1:0]       sum_top_s;
    logic [ACC_W-1:0]       sum_left_s;
    logic [BIT_WIDTH-1:0]   dc_s;
    logic [BIT_WIDTH-1:0]   dc_sel_s;
    logic [IDX_W-1:0]       row_idx_s;
    logic [BIT_WIDTH-1:0]   left_pix_s;
    logic [ROW_W-1:0]       row_s;

    // One predicted sample; TM is evaluated signed two bits wider than a sample
    // so both the negative and the above-max results can be clipped.
    function automatic logic [BIT_WIDTH-1:0] pred_pixel(
        input logic [1:0]           m,
        input logic                 t_ok,
        input logic                 l_ok,
        input logic [BIT_WIDTH-1:0] t_pix,
        input logic [BIT_WIDTH-1:0] l_pix,
        input logic [BIT_WIDTH-1:0] corner,
        input logic [BIT_WIDTH-1:0] dc
    );
        logic signed [BIT_WIDTH+1:0] tm;
        logic [BIT_WIDTH-1:0]        tm_clip;
        logic [BIT_WIDTH-1:0]        pix;
        tm = $signed({2'b00, t_pix}) + $signed({2'b00, l_pix}) - $signed({2'b00, corner});
        if (tm[BIT_WIDTH+1]) begin
            tm_clip = {BIT_WIDTH{1'b0}};
        end else if (tm[BIT_WIDTH]) begin
            tm_clip = {BIT_WIDTH{1'b1}};
        end else begin
            tm_clip = tm[BIT_WIDTH-1:0];
        end
        case (m)
            MODE_DC: pix = dc;
            MODE_TM: begin
                if (t_ok && l_ok) begin
                    pix = tm_clip;
                end else if (t_ok) begin
                    pix = t_pix;
                end else if (l_ok) begin
                    pix = l_pix;
                end else begin
                    pix = MID_P1;
                end
            end
            MODE_V:  pix = t_ok ? t_pix : MID_M1;
            MODE_H:  pix = l_ok ? l_pix : MID_P1;
            default: pix = dc;
        endcase
        return pix;
    endfunction

    assign in_ready    = (state_r == ST_IDLE) && !rst;
    assign out_row_idx = row_cnt_r;

    // DC value from the latched edges; accumulator is wide enough for all-max edges
    always_comb begin
        sum_top_s  = {ACC_W{1'b0}};
        sum_left_s = {ACC_W{1'b0}};
        for (int i = 0; i < BLOCK_SIZE; i++) begin
            sum_top_s  = sum_top_s  + ACC_W'(top_r[i*BIT_WIDTH +: BIT_WIDTH]);
            sum_left_s = sum_left_s + ACC_W'(left_r[i*BIT_WIDTH +: BIT_WIDTH]);
        end
        if (top_avail_r && left_avail_r) begin
            dc_s = BIT_WIDTH'((sum_top_s + sum_left_s + ACC_W'(BLOCK_SIZE)) >> (IDX_W + 1));
        end else if (top_avail_r) begin
            dc_s = BIT_WIDTH'((sum_top_s + ACC_W'(BLOCK_SIZE / 2)) >> IDX_W);
        end else if (left_avail_r) begin
            dc_s = BIT_WIDTH'((sum_left_s + ACC_W'(BLOCK_SIZE / 2)) >> IDX_W);
        end else begin
            dc_s = MID_PIX;
        end
    end

    // Row to load next: row 0 from CALC (DC not yet registered), else the following row
    always_comb begin
        if (state_r == ST_CALC) begin
            row_idx_s = {IDX_W{1'b0}};
            dc_sel_s  = dc_s;
        end else begin
            row_idx_s = row_cnt_r + ONE_IDX;
            dc_sel_s  = dc_r;
        end
    end

    // Predicted samples for the row selected above
    always_comb begin
        row_s      = {ROW_W{1'b0}};
        left_pix_s = left_r[int'(row_idx_s)*BIT_WIDTH +: BIT_WIDTH];
        for (int i = 0; i < BLOCK_SIZE; i++) begin
            row_s[i*BIT_WIDTH +: BIT_WIDTH] = pred_pixel(mode_r, top_avail_r, left_avail_r,
                                                         top_r[i*BIT_WIDTH +: BIT_WIDTH],
                                                         left_pix_s, top_left_r, dc_sel_s);
        end
    end

    // Control FSM with registered request capture and registered row outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            row_cnt_r    <= {IDX_W{1'b0}};
            out_valid    <= 1'b0;
            out_last     <= 1'b0;
            out_row      <= {ROW_W{1'b0}};
            dc_r         <= {BIT_WIDTH{1'b0}};
            mode_r       <= 2'd0;
            top_avail_r  <= 1'b0;
            left_avail_r <= 1'b0;
            top_left_r   <= {BIT_WIDTH{1'b0}};
            top_r        <= {ROW_W{1'b0}};
            left_r       <= {ROW_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        mode_r       <= mode;
                        top_avail_r  <= top_avail;
                        left_avail_r <= left_avail;
                        top_left_r   <= top_left;
                        top_r        <= top;
                        left_r       <= left;
                        state_r      <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    dc_r      <= dc_s;
                    row_cnt_r <= {IDX_W{1'b0}};
                    out_row   <= row_s;
                    out_valid <= 1'b1;
                    out_last  <= 1'b0;
                    state_r   <= ST_EMIT;
                end
                ST_EMIT: begin
                    if (out_ready) begin
                        if (out_last) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            state_r   <= ST_IDLE;
                        end else begin
                            row_cnt_r <= row_idx_s;
                            out_row   <= row_s;
                            out_last  <= (row_idx_s == LAST_IDX);
                        end
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_intra_pred_engine.sv
// Directed bench for intra_pred_engine: a 4x4 instance for modes, fallbacks,
// backpressure, reset and back-to-back traffic; a 16x16 instance for DC.
module tb_intra_pred_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   total = 0;
    int   bad   = 0;

    // 4x4 instance
    logic a_in_valid, a_in_ready, a_top_avail, a_left_avail;
    logic a_out_valid, a_out_ready, a_out_last;
    logic [1:0]  a_mode, a_out_row_idx;
    logic [7:0]  a_top_left;
    logic [31:0] a_top, a_left, a_out_row;

    // 16x16 instance
    logic b_in_valid, b_in_ready, b_top_avail, b_left_avail;
    logic b_out_valid, b_out_ready, b_out_last;
    logic [1:0]   b_mode;
    logic [3:0]   b_out_row_idx;
    logic [7:0]   b_top_left;
    logic [127:0] b_top, b_left, b_out_row;

    intra_pred_engine #(.BIT_WIDTH(8), .BLOCK_SIZE(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .mode(a_mode), .top_avail(a_top_avail), .left_avail(a_left_avail),
        .top_left(a_top_left), .top(a_top), .left(a_left),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_row(a_out_row),
        .out_row_idx(a_out_row_idx), .out_last(a_out_last)
    );

    intra_pred_engine #(.BIT_WIDTH(8), .BLOCK_SIZE(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .mode(b_mode), .top_avail(b_top_avail), .left_avail(b_left_avail),
        .top_left(b_top_left), .top(b_top), .left(b_left),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_row(b_out_row),
        .out_row_idx(b_out_row_idx), .out_last(b_out_last)
    );

    // Reference prediction of one 4-sample row, in plain integer arithmetic
    function automatic logic [31:0] exp_row4(input logic [1:0] m, input logic ta, input logic la,
                                             input logic [7:0] tl, input logic [31:0] t,
                                             input logic [31:0] l, input int j);
        int st, sl, dc, v, ti, lj, tli;
        logic [31:0] r;
        st = 0; sl = 0; tli = tl;
        for (int k = 0; k < 4; k++) begin
            st += t[k*8 +: 8];
            sl += l[k*8 +: 8];
        end
        lj = l[j*8 +: 8];
        if (ta && la) dc = (st + sl + 4) / 8;
        else if (ta)  dc = (st + 2) / 4;
        else if (la)  dc = (sl + 2) / 4;
        else          dc = 128;
        r = 32'd0;
        for (int i = 0; i < 4; i++) begin
            ti = t[i*8 +: 8];
            case (m)
                2'd0: v = dc;
                2'd1: begin
                    if (ta && la) begin
                        v = ti + lj - tli;
                        if (v < 0)   v = 0;
                        if (v > 255) v = 255;
                    end else if (ta) v = ti;
                    else if (la)     v = lj;
                    else             v = 129;
                end
                2'd2:    v = ta ? ti : 127;
                default: v = la ? lj : 129;
            endcase
            r[i*8 +: 8] = v[7:0];
        end
        return r;
    endfunction

    task automatic send4(input string name, input logic [1:0] m, input logic ta, input logic la,
                         input logic [7:0] tl, input logic [31:0] t, input logic [31:0] l);
        a_mode = m; a_top_avail = ta; a_left_avail = la; a_top_left = tl;
        a_top = t; a_left = l; a_in_valid = 1'b1;
        total++;
        if (a_in_ready !== 1'b1) begin
            bad++; $display("FAIL %s accept: in_ready got %b want 1", name, a_in_ready);
        end
        @(negedge clk);
        a_in_valid = 1'b0;
        a_mode = ~m; a_top_avail = ~ta; a_left_avail = ~la;
        a_top_left = ~tl; a_top = ~t; a_left = ~l;
        total++;
        if (a_out_valid !== 1'b0) begin
            bad++; $display("FAIL %s calc cycle: out_valid got %b want 0", name, a_out_valid);
        end
        @(negedge clk);
        total++;
        if (a_out_valid !== 1'b1) begin
            bad++; $display("FAIL %s latency: out_valid got %b want 1", name, a_out_valid);
        end
    endtask

    // rmode 0: ready always; 1: hold ready low 3 cycles on row 1; 2: random ready
    task automatic drain4(input string name, input logic [31:0] e [4], input int rmode,
                          output int cycles);
        int nxt = 0;
        int stall = 0;
        int guard = 0;
        cycles = 0;
        while (nxt < 4 && guard < 64) begin
            if (rmode == 1) begin
                a_out_ready = !(nxt == 1 && stall < 3);
                if (!a_out_ready) stall++;
            end else if (rmode == 2) begin
                a_out_ready = 1'($urandom_range(0, 1));
            end else begin
                a_out_ready = 1'b1;
            end
            if (a_out_valid === 1'b1) begin
                total++;
                if (a_out_row_idx !== 2'(nxt)) begin
                    bad++; $display("FAIL %s idx: got %0d want %0d", name, a_out_row_idx, nxt);
                end
                total++;
                if (a_out_row !== e[nxt]) begin
                    bad++; $display("FAIL %s row%0d: got %h want %h", name, nxt, a_out_row, e[nxt]);
                end
                total++;
                if (a_out_last !== (nxt == 3)) begin
                    bad++; $display("FAIL %s last row%0d: got %b", name, nxt, a_out_last);
                end
                if (a_out_ready) nxt++;
            end
            @(negedge clk);
            guard++;
            cycles++;
        end
        a_out_ready = 1'b1;
        total++;
        if (nxt != 4) begin
            bad++; $display("FAIL %s timeout: rows got %0d want 4", name, nxt);
        end
    endtask

    task automatic check_block4(input string name, input logic [1:0] m, input logic ta,
                                input logic la, input logic [7:0] tl, input logic [31:0] t,
                                input logic [31:0] l, input logic [31:0] e [4], input int rmode,
                                output int cycles);
        send4(name, m, ta, la, tl, t, l);
        drain4(name, e, rmode, cycles);
        total++;
        if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
            bad++; $display("FAIL %s end: out_valid=%b in_ready=%b want 0/1", name, a_out_valid, a_in_ready);
        end
    endtask

    task automatic check_fill16(input string name, input logic [1:0] m, input logic ta,
                                input logic la, input logic [127:0] t, input logic [127:0] l,
                                input logic [7:0] fill);
        logic [127:0] want;
        want = {16{fill}};
        b_mode = m; b_top_avail = ta; b_left_avail = la; b_top_left = 8'd0;
        b_top = t; b_left = l; b_in_valid = 1'b1; b_out_ready = 1'b1;
        total++;
        if (b_in_ready !== 1'b1) begin
            bad++; $display("FAIL %s accept: in_ready got %b want 1", name, b_in_ready);
        end
        @(negedge clk);
        b_in_valid = 1'b0;
        @(negedge clk);
        for (int r = 0; r < 16; r++) begin
            total++;
            if (b_out_valid !== 1'b1 || b_out_row_idx !== 4'(r) || b_out_last !== (r == 15)) begin
                bad++; $display("FAIL %s ctl row%0d: valid=%b idx=%0d last=%b", name, r, b_out_valid, b_out_row_idx, b_out_last);
            end
            total++;
            if (b_out_row !== want) begin
                bad++; $display("FAIL %s row%0d: got %h want %h", name, r, b_out_row, want);
            end
            @(negedge clk);
        end
        total++;
        if (b_in_ready !== 1'b1 || b_out_valid !== 1'b0) begin
            bad++; $display("FAIL %s end: in_ready=%b out_valid=%b", name, b_in_ready, b_out_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a_in_valid = 1'b1; a_mode = 2'd0; a_top_avail = 1'b1; a_left_avail = 1'b1;
        a_top_left = 8'd0; a_top = 32'd0; a_left = 32'd0; a_out_ready = 1'b1;
        b_in_valid = 1'b1; b_mode = 2'd0; b_top_avail = 1'b0; b_left_avail = 1'b0;
        b_top_left = 8'd0; b_top = 128'd0; b_left = 128'd0; b_out_ready = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (a_out_valid !== 1'b0 || a_out_last !== 1'b0 || a_out_row_idx !== 2'd0 || a_out_row !== 32'd0) begin
            bad++; $display("FAIL reset4: valid=%b last=%b idx=%0d row=%h want 0", a_out_valid, a_out_last, a_out_row_idx, a_out_row);
        end
        total++;
        if (b_out_valid !== 1'b0 || b_out_row !== 128'd0 || b_out_row_idx !== 4'd0) begin
            bad++; $display("FAIL reset16: valid=%b idx=%0d row=%h want 0", b_out_valid, b_out_row_idx, b_out_row);
        end
        total++;
        if (a_in_ready !== 1'b0) begin
            bad++; $display("FAIL reset in_ready: got %b want 0", a_in_ready);
        end
        rst = 1'b0; a_in_valid = 1'b0; b_in_valid = 1'b0;
        @(negedge clk);
        total++;
        if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin
            bad++; $display("FAIL reset no-accept: in_ready=%b/%b out_valid=%b want 1/1/0", a_in_ready, b_in_ready, a_out_valid);
        end
    endtask

    task automatic test_tm_example();
        logic [31:0] e [4];
        int cyc;
        e = '{{8'd25, 8'd15, 8'd5, 8'd0}, {8'd255, 8'd255, 8'd250, 8'd240},
              {8'd20, 8'd10, 8'd0, 8'd0}, {8'd21, 8'd11, 8'd1, 8'd0}};
        check_block4("tm_example", 2'd1, 1'b1, 1'b1, 8'd20, {8'd40, 8'd30, 8'd20, 8'd10},
                     {8'd1, 8'd0, 8'd250, 8'd5}, e, 0, cyc);
        total++;
        if (cyc != 4) begin
            bad++; $display("FAIL tm_example stall-free: cycles got %0d want 4", cyc);
        end
    endtask

    task automatic test_fallbacks();
        logic [31:0] e [4];
        logic [31:0] t, l;
        int cyc;
        t = {8'd40, 8'd30, 8'd20, 8'd10};
        l = {8'd1, 8'd0, 8'd250, 8'd5};
        e = '{4{{4{8'd127}}}};
        check_block4("v_no_top", 2'd2, 1'b0, 1'b1, 8'd9, t, l, e, 0, cyc);
        e = '{4{{4{8'd129}}}};
        check_block4("h_no_left", 2'd3, 1'b1, 1'b0, 8'd9, t, l, e, 0, cyc);
        check_block4("tm_none", 2'd1, 1'b0, 1'b0, 8'd9, t, l, e, 0, cyc);
        e = '{4{t}};
        check_block4("tm_as_v", 2'd1, 1'b1, 1'b0, 8'd9, t, l, e, 0, cyc);
        check_block4("v_top", 2'd2, 1'b1, 1'b1, 8'd9, t, l, e, 0, cyc);
        e = '{{4{8'd5}}, {4{8'd250}}, {4{8'd0}}, {4{8'd1}}};
        check_block4("tm_as_h", 2'd1, 1'b0, 1'b1, 8'd9, t, l, e, 0, cyc);
        e = '{4{{4{8'd45}}}};
        check_block4("dc4_both", 2'd0, 1'b1, 1'b1, 8'd9, t, l, e, 0, cyc);
    endtask

    task automatic test_dc16();
        check_fill16("dc16_max", 2'd0, 1'b1, 1'b1, {16{8'hFF}}, {16{8'hFF}}, 8'd255);
        check_fill16("dc16_top3", 2'd0, 1'b1, 1'b0, {16{8'd3}}, {16{8'd200}}, 8'd3);
        check_fill16("dc16_none", 2'd0, 1'b0, 1'b0, {16{8'd77}}, {16{8'd99}}, 8'd128);
        check_fill16("dc16_round", 2'd0, 1'b1, 1'b1, {16{8'd10}}, {16{8'd20}}, 8'd15);
        check_fill16("dc16_left7", 2'd0, 1'b0, 1'b1, {16{8'd200}}, {16{8'd7}}, 8'd7);
    endtask

    task automatic test_backpressure();
        logic [31:0] e [4];
        int cyc;
        e = '{{4{8'd11}}, {4{8'd22}}, {4{8'd33}}, {4{8'd44}}};
        check_block4("backpressure", 2'd3, 1'b0, 1'b1, 8'd0, 32'hDEADBEEF,
                     {8'd44, 8'd33, 8'd22, 8'd11}, e, 1, cyc);
        total++;
        if (cyc != 7) begin
            bad++; $display("FAIL backpressure cycles: got %0d want 7", cyc);
        end
    endtask

    task automatic test_reset_mid_block();
        logic [31:0] e [4];
        int cyc;
        a_out_ready = 1'b1;
        send4("midrst", 2'd3, 1'b1, 1'b1, 8'd0, 32'd0, {8'd44, 8'd33, 8'd22, 8'd11});
        repeat (2) @(negedge clk);
        total++;
        if (a_out_row_idx !== 2'd2 || a_out_row !== {4{8'd33}}) begin
            bad++; $display("FAIL midrst row2: idx=%0d row=%h want 2/%h", a_out_row_idx, a_out_row, {4{8'd33}});
        end
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (a_out_valid !== 1'b0) begin
            bad++; $display("FAIL midrst abort: out_valid got %b want 0", a_out_valid);
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin
            bad++; $display("FAIL midrst recover: in_ready=%b out_valid=%b want 1/0", a_in_ready, a_out_valid);
        end
        e = '{{8'd25, 8'd15, 8'd5, 8'd0}, {8'd255, 8'd255, 8'd250, 8'd240},
              {8'd20, 8'd10, 8'd0, 8'd0}, {8'd21, 8'd11, 8'd1, 8'd0}};
        check_block4("after_rst", 2'd1, 1'b1, 1'b1, 8'd20, {8'd40, 8'd30, 8'd20, 8'd10},
                     {8'd1, 8'd0, 8'd250, 8'd5}, e, 0, cyc);
    endtask

    task automatic test_back_to_back();
        logic [1:0]  pm  [4];
        logic        pta [4];
        logic        pla [4];
        logic [7:0]  ptl [4];
        logic [31:0] pt  [4];
        logic [31:0] pl  [4];
        logic [31:0] e   [4];
        int cyc, guard;
        for (int b = 0; b < 4; b++) begin
            pm[b] = 2'($urandom_range(0, 3));
            pta[b] = 1'($urandom_range(0, 1));
            pla[b] = 1'($urandom_range(0, 1));
            ptl[b] = 8'($urandom_range(0, 255));
            pt[b] = $urandom;
            pl[b] = $urandom;
        end
        pm[0] = 2'd1; pta[0] = 1'b1; pla[0] = 1'b1;
        a_mode = pm[0]; a_top_avail = pta[0]; a_left_avail = pla[0];
        a_top_left = ptl[0]; a_top = pt[0]; a_left = pl[0]; a_in_valid = 1'b1;
        for (int b = 0; b < 4; b++) begin
            guard = 0;
            while (a_in_ready !== 1'b1 && guard < 50) begin
                @(negedge clk);
                guard++;
            end
            total++;
            if (a_in_ready !== 1'b1) begin
                bad++; $display("FAIL b2b accept blk%0d: in_ready got %b want 1", b, a_in_ready);
            end
            @(negedge clk);
            if (b < 3) begin
                a_mode = pm[b+1]; a_top_avail = pta[b+1]; a_left_avail = pla[b+1];
                a_top_left = ptl[b+1]; a_top = pt[b+1]; a_left = pl[b+1];
            end else begin
                a_in_valid = 1'b0;
            end
            total++;
            if (a_in_ready !== 1'b0) begin
                bad++; $display("FAIL b2b single accept blk%0d: in_ready got %b want 0", b, a_in_ready);
            end
            @(negedge clk);
            total++;
            if (a_out_valid !== 1'b1) begin
                bad++; $display("FAIL b2b latency blk%0d: out_valid got %b want 1", b, a_out_valid);
            end
            for (int j = 0; j < 4; j++) e[j] = exp_row4(pm[b], pta[b], pla[b], ptl[b], pt[b], pl[b], j);
            drain4("b2b", e, 2, cyc);
        end
    endtask

    initial begin
        test_reset();
        test_tm_example();
        test_fallbacks();
        test_dc16();
        test_backpressure();
        test_reset_mid_block();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
